i2c_cfg_sequencer: RTL and testbench

Parametrised I2C register-initialisation sequencer for codec and peripheral bring-up.
- Walks a table of {register address, register data} entries and issues one 3-byte write per entry to I2C_Controller via its GO/END/ACK handshake.
- Additions over the fixed-table audio configurator: power-up delay, per-command NACK retry with a retry limit, done/error status, and re-run on request.
- Sits between the system clock-divider output (10 kHz I2C clock domain) and I2C_Controller.

---
 rtl/i2c_cfg_pkg.sv | 35 +++
 rtl/i2c_cfg_table.sv | 39 +++
 rtl/i2c_cfg_sequencer.sv | 140 ++++++++++++++
 tb/tb_i2c_cfg_sequencer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_cfg_pkg.sv
// Shared types and default WM8731 register table for the I2C config sequencer.
// Optional build macro I2C_CFG_TABLE_WR_EN enables a runtime-writable table.
package i2c_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PWRUP,
        LOAD,
        WAIT,
        CHECK,
        GAP,
        NEXT
    } cfg_state_e;

    localparam int GAP_CYCLES = 4;

    // Each entry is {reg[6:0], data[8:0]}
    function automatic logic [15:0] dflt_entry(input int idx);
        case (idx)
            0:       return {7'h0F, 9'h000};
            1:       return {7'h06, 9'h000};
            2:       return {7'h08, 9'h002};
            3:       return {7'h01, 9'h01A};
            4:       return {7'h00, 9'h01A};
            5:       return {7'h07, 9'h001};
            6:       return {7'h09, 9'h001};
            7:       return {7'h04, 9'h0F8};
            8:       return {7'h05, 9'h006};
            9:       return {7'h02, 9'h07B};
            10:      return {7'h03, 9'h07B};
            default: return 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/i2c_cfg_table.sv
// Register table: constant ROM by default, reset-initialised RAM when
// I2C_CFG_TABLE_WR_EN is defined. Read port is identical in both builds.
module i2c_cfg_table
    import i2c_cfg_pkg::*;
#(
    parameter int MAX_CMD = 16,
    parameter int IDX_W   = 4
) (
    input  logic [IDX_W-1:0] rd_addr,
    output logic [15:0]      rd_data
`ifdef I2C_CFG_TABLE_WR_EN
    ,
    input  logic             clk_i2c,
    input  logic             reset_n,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [15:0]      wdata
`endif
);

`ifdef I2C_CFG_TABLE_WR_EN
    logic [15:0] mem [MAX_CMD];

    always_ff @(posedge clk_i2c or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MAX_CMD; i++) begin
                mem[i] <= dflt_entry(i);
            end
        end else if (we && (int'(waddr) < MAX_CMD)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rd_data = mem[rd_addr];
`else
    assign rd_data = dflt_entry(int'(rd_addr));
`endif

endmodule

// File: rtl/i2c_cfg_sequencer.sv
// Walks the register table and issues one 3-byte I2C write per entry, with
// NACK retry, power-up delay and re-run. Macro: I2C_CFG_TABLE_WR_EN.
module i2c_cfg_sequencer
    import i2c_cfg_pkg::*;
#(
    parameter int         NUM_CMD   = 11,
    parameter int         MAX_CMD   = 16,
    parameter logic [6:0] DEV_ADDR  = 7'h1A,
    parameter int         REG_AW    = 7,
    parameter int         DATA_W    = 9,
    parameter int         MAX_RETRY = 3,
    parameter int         PWRUP_DLY = 32,
    localparam int        IDX_W     = $clog2(MAX_CMD)
) (
    input  logic             clk_i2c,
    input  logic             reset_n,
    input  logic             start,
    output logic [23:0]      i2c_data,
    output logic             i2c_go,
    input  logic             i2c_end,
    input  logic [2:0]       i2c_ack,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [IDX_W-1:0] cmd_idx,
    output logic [1:0]       retry_cnt
`ifdef I2C_CFG_TABLE_WR_EN
    ,
    input  logic             tbl_we,
    input  logic [IDX_W-1:0] tbl_addr,
    input  logic [15:0]      tbl_wdata
`endif
);

    if (REG_AW + DATA_W != 16) begin : g_bad_width
        $error("REG_AW + DATA_W must equal 16");
    end
    if (NUM_CMD < 1 || NUM_CMD > MAX_CMD) begin : g_bad_num
        $error("NUM_CMD must be in 1..MAX_CMD");
    end

    localparam int DLY_W = 16;
    localparam logic [DLY_W-1:0] PW_LAST  = DLY_W'(PWRUP_DLY - 1);
    localparam logic [DLY_W-1:0] GAP_LAST = DLY_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CMD - 1);
    localparam logic [1:0]       RTY_LIM  = 2'(MAX_RETRY);

    cfg_state_e       state_q, state_d;
    logic [DLY_W-1:0] dly_cnt;
    logic [15:0]      tbl_word;
    logic             nack, last_idx, can_retry, wait_armed;
    logic             clr_run, ld_xfer, ack_ok, inc_rty;
    logic             set_err, set_done, inc_idx;

    assign nack       = |i2c_ack;
    assign last_idx   = (cmd_idx == LAST_IDX);
    assign can_retry  = (retry_cnt < RTY_LIM);
    // First WAIT cycle may still see END held over from the previous transfer
    assign wait_armed = (dly_cnt != '0);

    i2c_cfg_table #(
        .MAX_CMD (MAX_CMD),
        .IDX_W   (IDX_W)
    ) u_table (
        .rd_addr (cmd_idx),
        .rd_data (tbl_word)
`ifdef I2C_CFG_TABLE_WR_EN
        ,
        .clk_i2c (clk_i2c),
        .reset_n (reset_n),
        .we      (tbl_we & ~busy),
        .waddr   (tbl_addr),
        .wdata   (tbl_wdata)
`endif
    );

    always_ff @(posedge clk_i2c or negedge reset_n) begin
        if (!reset_n) state_q <= PWRUP;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start) state_d = PWRUP;
            PWRUP: if (dly_cnt == PW_LAST) state_d = LOAD;
            LOAD:  state_d = WAIT;
            WAIT:  if (wait_armed && i2c_end) state_d = CHECK;
            CHECK: begin
                if (!nack)          state_d = NEXT;
                else if (can_retry) state_d = GAP;
                else                state_d = IDLE;
            end
            GAP:   if (dly_cnt == GAP_LAST) state_d = LOAD;
            NEXT:  state_d = last_idx ? IDLE : GAP;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        clr_run  = (state_q == IDLE) && start;
        ld_xfer  = (state_q == LOAD);
        ack_ok   = (state_q == CHECK) && !nack;
        inc_rty  = (state_q == CHECK) && nack && can_retry;
        set_err  = (state_q == CHECK) && nack && !can_retry;
        set_done = (state_q == NEXT) && last_idx;
        inc_idx  = (state_q == NEXT) && !last_idx;
    end

    always_ff @(posedge clk_i2c or negedge reset_n) begin
        if (!reset_n) begin
            i2c_go    <= 1'b0;
            i2c_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            cmd_idx   <= '0;
            retry_cnt <= '0;
            dly_cnt   <= '0;
        end else begin
            busy   <= (state_d != IDLE);
            i2c_go <= (state_d == WAIT);
            if (state_d != state_q) dly_cnt <= '0;
            else if (!(&dly_cnt))   dly_cnt <= dly_cnt + DLY_W'(1);
            if (ld_xfer) i2c_data <= {DEV_ADDR, 1'b0, tbl_word};
            if (clr_run) begin
                done      <= 1'b0;
                error     <= 1'b0;
                cmd_idx   <= '0;
                retry_cnt <= '0;
            end
            if (ack_ok)   retry_cnt <= '0;
            if (inc_rty)  retry_cnt <= retry_cnt + 2'd1;
            if (set_err)  error <= 1'b1;
            if (set_done) done <= 1'b1;
            if (inc_idx)  cmd_idx <= cmd_idx + IDX_W'(1);
        end
    end

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Randomised bench for i2c_cfg_sequencer with a transfer-list reference model.
// Table-write checks are compiled in when I2C_CFG_TABLE_WR_EN is defined.
module tb_i2c_cfg_sequencer;

    localparam int NUM  = 11;
    localparam int PW   = 32;
    localparam int MAXR = 3;

    logic        clk_i2c = 1'b0;
    logic        reset_n;
    logic        start;
    logic [23:0] i2c_data;
    logic        i2c_go;
    logic        i2c_end;
    logic [2:0]  i2c_ack;
    logic        busy, done, error;
    logic [3:0]  cmd_idx;
    logic [1:0]  retry_cnt;
`ifdef I2C_CFG_TABLE_WR_EN
    logic        tbl_we = 1'b0;
    logic [3:0]  tbl_addr = '0;
    logic [15:0] tbl_wdata = '0;
`endif

    always #5 clk_i2c = ~clk_i2c;

    i2c_cfg_sequencer dut (
        .clk_i2c   (clk_i2c),
        .reset_n   (reset_n),
        .start     (start),
        .i2c_data  (i2c_data),
        .i2c_go    (i2c_go),
        .i2c_end   (i2c_end),
        .i2c_ack   (i2c_ack),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .cmd_idx   (cmd_idx),
        .retry_cnt (retry_cnt)
`ifdef I2C_CFG_TABLE_WR_EN
        ,
        .tbl_we    (tbl_we),
        .tbl_addr  (tbl_addr),
        .tbl_wdata (tbl_wdata)
`endif
    );

    typedef struct {
        logic [23:0] data;
        int          idx;
        int          rty;
        bit          nack;
    } xfer_t;

    logic [6:0]  regs [NUM] = '{7'h0F, 7'h06, 7'h08, 7'h01, 7'h00, 7'h07,
                                7'h09, 7'h04, 7'h05, 7'h02, 7'h03};
    logic [8:0]  dats [NUM] = '{9'h000, 9'h000, 9'h002, 9'h01A, 9'h01A,
                                9'h001, 9'h001, 9'h0F8, 9'h006, 9'h07B,
                                9'h07B};
    logic [15:0] ref_tbl [NUM];
    int          nack [NUM];
    xfer_t       xq [$];
    int          n_run, n_fail, n_xfer, n_exp;
    bit          exp_done, exp_err;
    int          exp_idx, exp_rty;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected transfer list for one run from the table and NACK plan
    task automatic build();
        xq.delete();
        n_xfer   = 0;
        exp_err  = 0;
        exp_done = 1;
        exp_idx  = NUM - 1;
        exp_rty  = 0;
        for (int e = 0; e < NUM; e++) begin
            for (int k = 0; k <= MAXR; k++) begin
                xfer_t x;
                x.data = {7'h1A, 1'b0, ref_tbl[e]};
                x.idx  = e;
                x.rty  = k;
                x.nack = (k < nack[e]);
                xq.push_back(x);
                if (!x.nack) break;
                if (k == MAXR) begin
                    exp_err  = 1;
                    exp_done = 0;
                    exp_idx  = e;
                    exp_rty  = MAXR;
                    n_exp    = xq.size();
                    return;
                end
            end
        end
        n_exp = xq.size();
    endtask

    // Controller model: END rises a few cycles after GO, holds until next GO
    initial begin
        int    lat;
        bit    seen;
        xfer_t cur;
        i2c_end  = 1'b0;
        i2c_ack  = 3'b0;
        seen     = 0;
        lat      = 0;
        cur.nack = 0;
        forever begin
            @(posedge clk_i2c);
            #1;
            if (i2c_go && !seen) begin
                seen = 1;
                lat  = $urandom_range(2, 6);
                n_xfer++;
                if (xq.size() == 0) begin
                    chk("extra_xfer", n_xfer, n_exp);
                    cur.nack = 0;
                end else begin
                    cur = xq.pop_front();
                    chk("data", i2c_data, cur.data);
                    chk("idx", cmd_idx, cur.idx);
                    chk("retry", retry_cnt, cur.rty);
                    chk("busy_x", busy, 1);
                end
            end else if (i2c_go && lat > 0) begin
                lat--;
                i2c_end = (lat == 0);
                if (lat == 0)
                    i2c_ack = cur.nack ? 3'($urandom_range(1, 7)) : 3'b0;
            end else if (!i2c_go) begin
                if (seen && lat > 0 && reset_n)
                    chk("early_end", lat, 0);
                seen = 0;
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk_i2c);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_go(string tag);
        int n;
        n = 0;
        while (!i2c_go && n < 500) begin
            @(posedge clk_i2c);
            #1;
            n++;
        end
        chk(tag, n, PW + 1);
    endtask

    task automatic start_run();
        build();
        pulse_start();
        chk("done_clr", done, 0);
        chk("err_clr", error, 0);
        wait_go("pwrup_lat");
    endtask

    task automatic wait_end(bit mid);
        int i;
        i = 0;
        while ((busy || !(done || error)) && i < 4000) begin
            @(posedge clk_i2c);
            #1;
            i++;
            start = mid && (i == 60);
        end
        start = 1'b0;
        chk("timeout", i < 4000, 1);
        repeat (10) @(posedge clk_i2c);
        #1;
        chk("xfers", n_xfer, n_exp);
        chk("done", done, exp_done);
        chk("error", error, exp_err);
        chk("idx_end", cmd_idx, exp_idx);
        chk("retry_end", retry_cnt, exp_rty);
        chk("busy_end", busy, 0);
        chk("go_end", i2c_go, 0);
    endtask

    task automatic clr_nack();
        for (int e = 0; e < NUM; e++) nack[e] = 0;
    endtask

    initial begin
        int n;
        n_run   = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        start   = 1'b0;
        for (int e = 0; e < NUM; e++) ref_tbl[e] = {regs[e], dats[e]};
        clr_nack();
        build();
        repeat (3) @(posedge clk_i2c);
        #1;
        chk("rst_go", i2c_go, 0);
        chk("rst_data", i2c_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", error, 0);
        chk("rst_idx", cmd_idx, 0);
        chk("rst_rty", retry_cnt, 0);
        reset_n = 1'b1;
        wait_go("rst_pwrup_lat");
        wait_end(0);

        nack[3] = 1;
        start_run();
        wait_end(0);

        clr_nack();
        nack[5] = 4;
        start_run();
        wait_end(0);

        clr_nack();
        start_run();
        wait_end(1);

        start_run();
        n = 0;
        while (n_xfer < 8 && n < 2000) begin
            @(posedge clk_i2c);
            #1;
            n++;
        end
        chk("reach_e7", n_xfer, 8);
        #3;
        reset_n = 1'b0;
        #1;
        chk("go_async", i2c_go, 0);
        chk("busy_async", busy, 0);
        chk("idx_async", cmd_idx, 0);
        build();
        @(posedge clk_i2c);
        @(posedge clk_i2c);
        #1;
        reset_n = 1'b1;
        wait_go("rerun_lat");
        wait_end(0);

        for (int r = 0; r < 6; r++) begin
            for (int e = 0; e < NUM; e++) begin
                int v;
                v = $urandom_range(0, 19);
                nack[e] = (v < 16) ? 0 : (v < 18) ? 1 : (v == 18) ? 3 : 4;
            end
            start_run();
            wait_end(r[0]);
        end

`ifdef I2C_CFG_TABLE_WR_EN
        clr_nack();
        tbl_addr  = 4'd9;
        tbl_wdata = 16'h0479;
        tbl_we    = 1'b1;
        @(posedge clk_i2c);
        #1;
        tbl_we     = 1'b0;
        ref_tbl[9] = 16'h0479;
        start_run();
        tbl_addr  = 4'd2;
        tbl_wdata = 16'hFFFF;
        tbl_we    = 1'b1;
        @(posedge clk_i2c);
        #1;
        tbl_we = 1'b0;
        wait_end(0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
